// File: rtl/mole_scheduler_if.sv
// mole_scheduler_if: control bundle between the mole scheduler and the game
// controller. The controller issues start/hit; the scheduler reports which
// mole is up, when it expired unhit, and the running score.
interface mole_scheduler_if;
    logic       start;
    logic       hit;
    logic [1:0] mole_sel;
    logic       mole_valid;
    logic       timer_pulse;
    logic [7:0] score;
    logic [7:0] misses;
    logic       game_over;

    // Game controller side: requests games, reports whacks, observes moles.
    modport master (
        output start,
        output hit,
        input  mole_sel,
        input  mole_valid,
        input  timer_pulse,
        input  score,
        input  misses,
        input  game_over
    );

    // Scheduler side.
    modport slave (
        input  start,
        input  hit,
        output mole_sel,
        output mole_valid,
        output timer_pulse,
        output score,
        output misses,
        output game_over
    );
endinterface

// File: rtl/mole_scheduler.sv
// mole_scheduler: round sequencer for the whack-a-mole game. Picks a mole
// pseudo-randomly (never the same one twice in a row), keeps it up for the
// round length, counts hits and misses, and pauses for a blank gap between
// rounds. A game is ROUNDS moles long.
//
// Optional feature macro: MOLE_SPEEDUP_EN -- when defined, every hit shortens
// the mole-up time by STEP_MS, floored at MIN_ROUND_MS. When undefined the
// mole-up time stays at ROUND_MS.
module mole_scheduler #(
    parameter int          TICKS_PER_MS = 50000,
    parameter int          ROUND_MS     = 1000,
    parameter int          MIN_ROUND_MS = 300,
    parameter int          STEP_MS      = 50,
    parameter int          GAP_MS       = 250,
    parameter int          ROUNDS       = 30,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic           clk,
    input  logic           reset,
    mole_scheduler_if.slave bus
);

`ifdef MOLE_SPEEDUP_EN
    localparam bit SPEEDUP_EN = 1'b1;
`else
    localparam bit SPEEDUP_EN = 1'b0;
`endif

    // Prescaler needs at least one bit even when a ms is a single clock.
    localparam int            PW       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_MS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_UP,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_reg;
    logic [15:0]   lfsr_reg;
    logic [PW-1:0] pre_reg;
    logic [9:0]    ms_reg;
    logic [9:0]    len_reg;
    logic [7:0]    round_reg;
    logic [7:0]    score_reg;
    logic [7:0]    misses_reg;
    logic [1:0]    sel_reg;
    logic          valid_reg;
    logic          pulse_reg;
    logic          over_reg;

    logic          ms_tick;
    logic          ms_last;
    logic [1:0]    cand;
    logic [1:0]    sel_next;
    logic [10:0]   len_diff;
    logic [9:0]    len_next;

    // Millisecond tick, expiry detection, next mole choice and sped-up length.
    always_comb begin
        ms_tick  = (pre_reg == PRE_LAST);
        ms_last  = ms_tick && (ms_reg == 10'd1);
        cand     = lfsr_reg[1:0];
        sel_next = (cand == sel_reg) ? cand + 2'd1 : cand;
        // 11-bit difference: bit 10 set means the step overshot zero.
        len_diff = {1'b0, len_reg} - 11'(STEP_MS);
        if (len_diff[10] || (len_diff[9:0] < 10'(MIN_ROUND_MS))) begin
            len_next = 10'(MIN_ROUND_MS);
        end else begin
            len_next = len_diff[9:0];
        end
    end

    // Free-running Fibonacci LFSR, taps 16,14,13,11, advances every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    // Game sequencer: state, timers, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            pre_reg    <= '0;
            ms_reg     <= '0;
            len_reg    <= 10'(ROUND_MS);
            round_reg  <= '0;
            score_reg  <= '0;
            misses_reg <= '0;
            sel_reg    <= '0;
            valid_reg  <= 1'b0;
            pulse_reg  <= 1'b0;
            over_reg   <= 1'b0;
        end else begin
            pulse_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        score_reg  <= '0;
                        misses_reg <= '0;
                        round_reg  <= '0;
                        over_reg   <= 1'b0;
                        len_reg    <= 10'(ROUND_MS);
                        state_reg  <= S_ARM;
                    end
                end

                S_ARM: begin
                    sel_reg   <= sel_next;
                    valid_reg <= 1'b1;
                    ms_reg    <= len_reg;
                    pre_reg   <= '0;
                    state_reg <= S_UP;
                end

                S_UP: begin
                    if (ms_tick) begin
                        pre_reg <= '0;
                        ms_reg  <= ms_reg - 10'd1;
                    end else begin
                        pre_reg <= pre_reg + 1'b1;
                    end
                    // A hit takes priority over an expiry in the same cycle.
                    if (bus.hit) begin
                        if (score_reg != 8'hFF) begin
                            score_reg <= score_reg + 8'd1;
                        end
                        if (SPEEDUP_EN) begin
                            len_reg <= len_next;
                        end
                        valid_reg <= 1'b0;
                        ms_reg    <= 10'(GAP_MS);
                        pre_reg   <= '0;
                        state_reg <= S_GAP;
                    end else if (ms_last) begin
                        if (misses_reg != 8'hFF) begin
                            misses_reg <= misses_reg + 8'd1;
                        end
                        valid_reg <= 1'b0;
                        pulse_reg <= 1'b1;
                        ms_reg    <= 10'(GAP_MS);
                        pre_reg   <= '0;
                        state_reg <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (ms_tick) begin
                        pre_reg <= '0;
                        ms_reg  <= ms_reg - 10'd1;
                    end else begin
                        pre_reg <= pre_reg + 1'b1;
                    end
                    if (ms_last) begin
                        round_reg <= round_reg + 8'd1;
                        if ((round_reg + 8'd1) == 8'(ROUNDS)) begin
                            over_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_ARM;
                        end
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mole_sel    = sel_reg;
    assign bus.mole_valid  = valid_reg;
    assign bus.timer_pulse = pulse_reg;
    assign bus.score       = score_reg;
    assign bus.misses      = misses_reg;
    assign bus.game_over   = over_reg;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed bench for mole_scheduler. A cycle-count model of
// the game rules runs alongside the DUT and is compared on every falling edge;
// literal expectations pin game totals, durations and mole-selection rules.
module tb_mole_scheduler;
    localparam int T     = 4;
    localparam int RMS   = 3;
    localparam int MINMS = 1;
    localparam int STEP  = 1;
    localparam int GAPMS = 2;
    localparam int NR    = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_ARM  = 1;
    localparam int PH_UP   = 2;
    localparam int PH_GAP  = 3;
    localparam int PH_DONE = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mole_scheduler_if bus();

    mole_scheduler #(
        .TICKS_PER_MS (T),
        .ROUND_MS     (RMS),
        .MIN_ROUND_MS (MINMS),
        .STEP_MS      (STEP),
        .GAP_MS       (GAPMS),
        .ROUNDS       (NR),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- behavioural model (cycle counts, not ms/prescaler) ---------
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    int          m_phase = PH_IDLE;
    int          m_left  = 0;
    int          m_len   = RMS;
    int          m_round = 0;
    int          m_score = 0;
    int          m_miss  = 0;
    int          m_sel   = 0;
    int          m_valid = 0;
    int          m_pulse = 0;
    int          m_over  = 0;
    logic [15:0] m_lfsr  = 16'hACE1;
    logic [15:0] m_cur;
    int          m_cand;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_phase = PH_IDLE; m_left = 0; m_len = RMS; m_round = 0;
            m_score = 0; m_miss = 0; m_sel = 0; m_valid = 0; m_pulse = 0;
            m_over = 0; m_lfsr = 16'hACE1;
        end else begin
            m_cur   = m_lfsr;
            m_lfsr  = lfsr_step(m_lfsr);
            m_pulse = 0;
            case (m_phase)
                PH_IDLE, PH_DONE: begin
                    if (bus.start) begin
                        m_score = 0; m_miss = 0; m_round = 0; m_over = 0;
                        m_len = RMS; m_phase = PH_ARM;
                    end
                end
                PH_ARM: begin
                    m_cand = int'(m_cur[1:0]);
                    if (m_cand == m_sel) m_cand = (m_cand + 1) % 4;
                    m_sel   = m_cand;
                    m_valid = 1;
                    m_left  = T * m_len;
                    m_phase = PH_UP;
                end
                PH_UP: begin
                    m_left--;
                    if (bus.hit) begin
                        m_score = (m_score < 255) ? m_score + 1 : 255;
`ifdef MOLE_SPEEDUP_EN
                        m_len = (m_len - STEP < MINMS) ? MINMS : m_len - STEP;
`endif
                        m_valid = 0;
                        m_left  = T * GAPMS;
                        m_phase = PH_GAP;
                    end else if (m_left == 0) begin
                        m_miss  = (m_miss < 255) ? m_miss + 1 : 255;
                        m_valid = 0;
                        m_pulse = 1;
                        m_left  = T * GAPMS;
                        m_phase = PH_GAP;
                    end
                end
                PH_GAP: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_round++;
                        if (m_round == NR) begin
                            m_over  = 1;
                            m_phase = PH_DONE;
                        end else begin
                            m_phase = PH_ARM;
                        end
                    end
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare and rule monitors ----------------------
    int prev_valid = 0;
    int prev_pulse = 0;
    int run_len    = 0;
    int run_q[$];
    int pulse_cnt  = 0;
    int rise_cnt   = 0;
    int last_sel   = 0;

    initial forever begin
        @(negedge clk);
        checks++;
        if (bus.mole_sel !== 2'(m_sel) || bus.mole_valid !== 1'(m_valid) ||
            bus.timer_pulse !== 1'(m_pulse) || bus.score !== 8'(m_score) ||
            bus.misses !== 8'(m_miss) || bus.game_over !== 1'(m_over)) begin
            errors++;
            $display("FAIL model_compare t=%0t: dut sel=%0d valid=%0b pulse=%0b score=%0d misses=%0d over=%0b, model sel=%0d valid=%0d pulse=%0d score=%0d misses=%0d over=%0d",
                     $time, bus.mole_sel, bus.mole_valid, bus.timer_pulse, bus.score,
                     bus.misses, bus.game_over, m_sel, m_valid, m_pulse, m_score, m_miss, m_over);
        end
        if (reset) begin
            prev_valid = 0; prev_pulse = 0; run_len = 0; last_sel = 0;
        end else begin
            if (bus.mole_valid && !prev_valid) begin
                rise_cnt++;
                checks++;
                if (int'(bus.mole_sel) == last_sel) begin
                    errors++;
                    $display("FAIL sel_repeat: got %0d, required different from %0d", bus.mole_sel, last_sel);
                end
                last_sel = int'(bus.mole_sel);
            end
            if (bus.mole_valid) begin
                run_len++;
            end else if (prev_valid) begin
                run_q.push_back(run_len);
                run_len = 0;
            end
            if (bus.timer_pulse) begin
                pulse_cnt++;
                checks++;
                if (prev_pulse || bus.mole_valid || !prev_valid) begin
                    errors++;
                    $display("FAIL pulse_shape: prev_pulse=%0d valid=%0b prev_valid=%0d, required 0/0/1",
                             prev_pulse, bus.mole_valid, prev_valid);
                end
            end
            prev_valid = int'(bus.mole_valid);
            prev_pulse = int'(bus.timer_pulse);
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_rise(input string name);
        int n = 0;
        while (!bus.mole_valid && n < 60) begin
            tick();
            n++;
        end
        check(name, int'(bus.mole_valid), 1);
    endtask

    task automatic wait_over(input string name);
        int n = 0;
        while (!bus.game_over && n < 400) begin
            tick();
            n++;
        end
        check(name, int'(bus.game_over), 1);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.hit   = 1'b0;
        reset     = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset values
        check("rst_sel", int'(bus.mole_sel), 0);
        check("rst_valid", int'(bus.mole_valid), 0);
        check("rst_pulse", int'(bus.timer_pulse), 0);
        check("rst_score", int'(bus.score), 0);
        check("rst_misses", int'(bus.misses), 0);
        repeat (10) tick();
        check("idle_game_over", int'(bus.game_over), 0);
        $display("reset: outputs idle");

        // No hits: four 12-cycle moles, four pulses, done after 84 cycles
        run_q.delete();
        pulse_cnt = 0;
        pulse_start();
        tick();
        check("valid_after_start", int'(bus.mole_valid), 1);
        n = 1;
        while (!bus.game_over && n < 300) begin
            tick();
            n++;
        end
        check("nohit_game_cycles", n, 84);
        check("nohit_misses", int'(bus.misses), 4);
        check("nohit_score", int'(bus.score), 0);
        check("nohit_game_over", int'(bus.game_over), 1);
        check("nohit_pulses", pulse_cnt, 4);
        check("nohit_runs", run_q.size(), 4);
        foreach (run_q[i]) check("nohit_run_len", run_q[i], 12);
        $display("game no-hit: score=%0d misses=%0d", bus.score, bus.misses);

        // Hit every round two cycles after the rise; one stray hit in a gap
        pulse_cnt = 0;
        pulse_start();
        for (int r = 0; r < NR; r++) begin
            wait_rise("hit_game_rise");
            tick();
            bus.hit = 1'b1;
            tick();
            bus.hit = 1'b0;
            check("hit_score_step", int'(bus.score), r + 1);
            check("hit_valid_drop", int'(bus.mole_valid), 0);
            if (r == 1) begin
                bus.hit = 1'b1;
                tick();
                bus.hit = 1'b0;
                tick();
                check("gap_hit_ignored", int'(bus.score), 2);
            end
        end
        wait_over("hit_game_over");
        check("hit_score", int'(bus.score), 4);
        check("hit_misses", int'(bus.misses), 0);
        check("hit_pulses", pulse_cnt, 0);
        $display("game hit-all: score=%0d misses=%0d", bus.score, bus.misses);

        // Hit lands on the final tick of the first mole
        pulse_cnt = 0;
        pulse_start();
        wait_rise("simul_rise");
        repeat (11) tick();
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        check("simul_score", int'(bus.score), 1);
        check("simul_misses", int'(bus.misses), 0);
        check("simul_pulse", int'(bus.timer_pulse), 0);
        check("simul_valid", int'(bus.mole_valid), 0);
        wait_over("simul_game_over");
        check("simul_end_misses", int'(bus.misses), 3);
        check("simul_end_pulses", pulse_cnt, 3);
        $display("game simultaneous: score=%0d misses=%0d", bus.score, bus.misses);

        // Long run of games: every mole differs from the previous one
        rise_cnt = 0;
        for (int g = 0; g < 8; g++) begin
            pulse_start();
            wait_over("sel_game_over");
        end
        check("sel_rounds_seen", rise_cnt, 8 * NR);
        $display("selection: %0d moles observed", rise_cnt);

        // Reset in the middle of a mole
        pulse_start();
        wait_rise("rstmid_rise");
        repeat (5) tick();
        pulse_cnt = 0;
        #2 reset = 1'b1;
        #1;
        check("rstmid_valid", int'(bus.mole_valid), 0);
        check("rstmid_pulse", int'(bus.timer_pulse), 0);
        check("rstmid_score", int'(bus.score), 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        check("rstmid_no_pulse", pulse_cnt, 0);
        check("rstmid_idle_valid", int'(bus.mole_valid), 0);
        check("rstmid_idle_over", int'(bus.game_over), 0);
        $display("reset mid-round: valid=%0b", bus.mole_valid);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
